// File: rtl/re_mapper_multi.sv
// re_mapper_multi: PUSCH resource-element mapper for one slot.
//
// Walks the allocated symbols Sym_Start..Sym_End. For each symbol it writes
// Nre = 12*N_rb REs at grid addresses N_sc..N_sc+Nre-1 in ascending order.
// Symbols flagged in Dmrs_Mask take DMRS samples on the comb (k[0]==Comb_Off)
// and zeros elsewhere. All other symbols take FFT samples.
//
// Ports:
//   CLK_RE, RST_RE        clock, asynchronous active-high reset
//   Start, Abort          slot start pulse (latches config), synchronous abort
//   N_sc, N_rb            first subcarrier, number of allocated RBs
//   Sym_Start, Sym_End    allocated symbol range
//   Dmrs_Mask, Comb_Off   DMRS symbol bitmask, DMRS comb offset
//   Dmrs_I/Q/Valid/Ready  DMRS sample stream (valid/ready)
//   FFT_I/Q/Valid/Ready   FFT sample stream (valid/ready)
//   RE_Real, RE_Imj       registered RE value
//   RE_Valid_OUT          write strobe, Wr_addr / Wr_sym give the grid location
//   Sym_Done, RE_Done     last write of a symbol, slot complete
//   Busy, Cfg_Err         not idle, Start rejected by the config check
module re_mapper_multi #(
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned DMRS_W    = 9,
    parameter int unsigned NSC_TOTAL = 1200,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned NSYM      = 14
) (
    input  logic                     CLK_RE,
    input  logic                     RST_RE,
    input  logic                     Start,
    input  logic                     Abort,
    input  logic [ADDR_W-1:0]        N_sc,
    input  logic [6:0]               N_rb,
    input  logic [3:0]               Sym_Start,
    input  logic [3:0]               Sym_End,
    input  logic [NSYM-1:0]          Dmrs_Mask,
    input  logic                     Comb_Off,
    input  logic signed [DMRS_W-1:0] Dmrs_I,
    input  logic signed [DMRS_W-1:0] Dmrs_Q,
    input  logic                     Dmrs_Valid,
    output logic                     Dmrs_Ready,
    input  logic signed [DATA_W-1:0] FFT_I,
    input  logic signed [DATA_W-1:0] FFT_Q,
    input  logic                     FFT_Valid,
    output logic                     FFT_Ready,
    output logic signed [DATA_W-1:0] RE_Real,
    output logic signed [DATA_W-1:0] RE_Imj,
    output logic                     RE_Valid_OUT,
    output logic [ADDR_W-1:0]        Wr_addr,
    output logic [3:0]               Wr_sym,
    output logic                     Sym_Done,
    output logic                     RE_Done,
    output logic                     Busy,
    output logic                     Cfg_Err
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StMapDmrs,
        StMapData,
        StNextSym,
        StDone
    } state_e;

    // One extra bit so N_sc + 12*N_rb cannot wrap before the range check.
    localparam int unsigned CW = ADDR_W + 1;

    state_e state_q, state_d;

    // Configuration latched on Start
    logic [ADDR_W-1:0] n_sc_q, n_sc_d;
    logic [6:0]        n_rb_q, n_rb_d;
    logic [3:0]        sym_start_q, sym_start_d;
    logic [3:0]        sym_end_q, sym_end_d;
    logic [NSYM-1:0]   mask_q, mask_d;
    logic              comb_q, comb_d;

    // Walk counters
    logic [3:0]        sym_q, sym_d;
    logic [CW-1:0]     k_q, k_d;
    logic [CW-1:0]     nre_q, nre_d;

    // Registered write port
    logic signed [DATA_W-1:0] re_real_q, re_real_d;
    logic signed [DATA_W-1:0] re_imj_q, re_imj_d;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic [3:0]               wr_sym_q, wr_sym_d;
    logic                     re_valid_q, re_valid_d;
    logic                     sym_done_q, sym_done_d;
    logic                     re_done_q, re_done_d;
    logic                     cfg_err_q, cfg_err_d;

    logic          dmrs_ready, fft_ready;
    logic          accept;
    logic          abort_act;
    logic          on_comb;
    logic          last_re;
    logic          cfg_bad;
    logic [CW-1:0] span_end;
    logic [CW-1:0] nre_cfg;
    logic signed [DATA_W-1:0] smp_i, smp_q;

    assign abort_act = Abort && (state_q != StIdle);
    assign on_comb   = (k_q[0] == comb_q);
    assign last_re   = (k_q == nre_q - CW'(1));
    assign nre_cfg   = CW'(n_rb_q) * CW'(12);
    assign span_end  = CW'(n_sc_q) + nre_cfg;
    assign cfg_bad   = (n_rb_q == 7'd0) || (span_end > CW'(NSC_TOTAL)) ||
                       (sym_start_q > sym_end_q) || (sym_end_q > 4'(NSYM - 1));

    always_comb begin
        state_d     = state_q;
        n_sc_d      = n_sc_q;
        n_rb_d      = n_rb_q;
        sym_start_d = sym_start_q;
        sym_end_d   = sym_end_q;
        mask_d      = mask_q;
        comb_d      = comb_q;
        sym_d       = sym_q;
        k_d         = k_q;
        nre_d       = nre_q;
        re_real_d   = re_real_q;
        re_imj_d    = re_imj_q;
        wr_addr_d   = wr_addr_q;
        wr_sym_d    = wr_sym_q;
        re_valid_d  = 1'b0;
        sym_done_d  = 1'b0;
        re_done_d   = 1'b0;
        cfg_err_d   = 1'b0;
        dmrs_ready  = 1'b0;
        fft_ready   = 1'b0;
        accept      = 1'b0;
        smp_i       = '0;
        smp_q       = '0;

        case (state_q)
            StIdle: begin
                if (Start) begin
                    n_sc_d      = N_sc;
                    n_rb_d      = N_rb;
                    sym_start_d = Sym_Start;
                    sym_end_d   = Sym_End;
                    mask_d      = Dmrs_Mask;
                    comb_d      = Comb_Off;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (cfg_bad) begin
                    cfg_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    sym_d   = sym_start_q;
                    k_d     = '0;
                    nre_d   = nre_cfg;
                    state_d = mask_q[sym_start_q] ? StMapDmrs : StMapData;
                end
            end
            StMapDmrs: begin
                if (on_comb) begin
                    dmrs_ready = 1'b1;
                    accept     = Dmrs_Valid;
                    // Size cast of a signed operand sign-extends to DATA_W.
                    smp_i      = DATA_W'(Dmrs_I);
                    smp_q      = DATA_W'(Dmrs_Q);
                end else begin
                    // Off-comb REs are written as zero without consuming a sample.
                    accept = 1'b1;
                end
            end
            StMapData: begin
                fft_ready = 1'b1;
                accept    = FFT_Valid;
                smp_i     = FFT_I;
                smp_q     = FFT_Q;
            end
            StNextSym: begin
                if (sym_q == sym_end_q) begin
                    state_d = StDone;
                end else begin
                    sym_d   = sym_q + 4'd1;
                    k_d     = '0;
                    state_d = mask_q[sym_q + 4'd1] ? StMapDmrs : StMapData;
                end
            end
            StDone: begin
                re_done_d = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept && !abort_act) begin
            re_valid_d = 1'b1;
            re_real_d  = smp_i;
            re_imj_d   = smp_q;
            wr_addr_d  = n_sc_q + k_q[ADDR_W-1:0];
            wr_sym_d   = sym_q;
            sym_done_d = last_re;
            k_d        = k_q + CW'(1);
            if (last_re) begin
                state_d = StNextSym;
            end
        end

        // Abort wins over every transition; writes already registered still show.
        if (abort_act) begin
            state_d    = StIdle;
            dmrs_ready = 1'b0;
            fft_ready  = 1'b0;
            re_done_d  = 1'b0;
            cfg_err_d  = 1'b0;
            sym_done_d = 1'b0;
            re_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_RE or posedge RST_RE) begin
        if (RST_RE) begin
            state_q     <= StIdle;
            n_sc_q      <= '0;
            n_rb_q      <= '0;
            sym_start_q <= '0;
            sym_end_q   <= '0;
            mask_q      <= '0;
            comb_q      <= 1'b0;
            sym_q       <= '0;
            k_q         <= '0;
            nre_q       <= '0;
            re_real_q   <= '0;
            re_imj_q    <= '0;
            wr_addr_q   <= '0;
            wr_sym_q    <= '0;
            re_valid_q  <= 1'b0;
            sym_done_q  <= 1'b0;
            re_done_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_sc_q      <= n_sc_d;
            n_rb_q      <= n_rb_d;
            sym_start_q <= sym_start_d;
            sym_end_q   <= sym_end_d;
            mask_q      <= mask_d;
            comb_q      <= comb_d;
            sym_q       <= sym_d;
            k_q         <= k_d;
            nre_q       <= nre_d;
            re_real_q   <= re_real_d;
            re_imj_q    <= re_imj_d;
            wr_addr_q   <= wr_addr_d;
            wr_sym_q    <= wr_sym_d;
            re_valid_q  <= re_valid_d;
            sym_done_q  <= sym_done_d;
            re_done_q   <= re_done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign Dmrs_Ready   = dmrs_ready;
    assign FFT_Ready    = fft_ready;
    assign RE_Real      = re_real_q;
    assign RE_Imj       = re_imj_q;
    assign RE_Valid_OUT = re_valid_q;
    assign Wr_addr      = wr_addr_q;
    assign Wr_sym       = wr_sym_q;
    assign Sym_Done     = sym_done_q;
    assign RE_Done      = re_done_q;
    assign Busy         = (state_q != StIdle);
    assign Cfg_Err      = cfg_err_q;

endmodule

// File: tb/tb_re_mapper_multi.sv
// Directed bench for re_mapper_multi: a small per-RE model predicts readies,
// write strobes, addresses, values and completion pulses cycle by cycle.
module tb_re_mapper_multi;

    localparam int DATA_W = 18;
    localparam int DMRS_W = 9;
    localparam int ADDR_W = 11;
    localparam int NSYM   = 14;

    logic                     CLK_RE, RST_RE, Start, Abort;
    logic [ADDR_W-1:0]        N_sc;
    logic [6:0]               N_rb;
    logic [3:0]               Sym_Start, Sym_End;
    logic [NSYM-1:0]          Dmrs_Mask;
    logic                     Comb_Off;
    logic signed [DMRS_W-1:0] Dmrs_I, Dmrs_Q;
    logic                     Dmrs_Valid, Dmrs_Ready;
    logic signed [DATA_W-1:0] FFT_I, FFT_Q;
    logic                     FFT_Valid, FFT_Ready;
    logic signed [DATA_W-1:0] RE_Real, RE_Imj;
    logic                     RE_Valid_OUT;
    logic [ADDR_W-1:0]        Wr_addr;
    logic [3:0]               Wr_sym;
    logic                     Sym_Done, RE_Done, Busy, Cfg_Err;

    int errors = 0;
    int checks = 0;

    // Configuration of the slot currently under test
    int              t_nsc, t_nrb, t_ss, t_se;
    logic [NSYM-1:0] t_mask;
    logic            t_comb;
    logic [DMRS_W-1:0] t_di, t_dq;

    re_mapper_multi dut (
        .CLK_RE       (CLK_RE),
        .RST_RE       (RST_RE),
        .Start        (Start),
        .Abort        (Abort),
        .N_sc         (N_sc),
        .N_rb         (N_rb),
        .Sym_Start    (Sym_Start),
        .Sym_End      (Sym_End),
        .Dmrs_Mask    (Dmrs_Mask),
        .Comb_Off     (Comb_Off),
        .Dmrs_I       (Dmrs_I),
        .Dmrs_Q       (Dmrs_Q),
        .Dmrs_Valid   (Dmrs_Valid),
        .Dmrs_Ready   (Dmrs_Ready),
        .FFT_I        (FFT_I),
        .FFT_Q        (FFT_Q),
        .FFT_Valid    (FFT_Valid),
        .FFT_Ready    (FFT_Ready),
        .RE_Real      (RE_Real),
        .RE_Imj       (RE_Imj),
        .RE_Valid_OUT (RE_Valid_OUT),
        .Wr_addr      (Wr_addr),
        .Wr_sym       (Wr_sym),
        .Sym_Done     (Sym_Done),
        .RE_Done      (RE_Done),
        .Busy         (Busy),
        .Cfg_Err      (Cfg_Err)
    );

    initial CLK_RE = 1'b0;
    always #5 CLK_RE = ~CLK_RE;

    task automatic tick();
        @(posedge CLK_RE);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(RE_Valid_OUT), 0);
        check({tag, "_addr"}, 32'(Wr_addr), 0);
        check({tag, "_sym"}, 32'(Wr_sym), 0);
        check({tag, "_real"}, $unsigned(RE_Real), 0);
        check({tag, "_imj"}, $unsigned(RE_Imj), 0);
        check({tag, "_flags"}, {28'd0, Sym_Done, RE_Done, Busy, Cfg_Err}, 0);
        check({tag, "_ready"}, {30'd0, Dmrs_Ready, FFT_Ready}, 0);
    endtask

    // Issue Start with a configuration, then walk through the CHECK cycle.
    task automatic start_slot(input int nsc, input int nrb, input int ss, input int se,
                              input logic [NSYM-1:0] mask, input logic comb,
                              input logic [DMRS_W-1:0] di, input logic [DMRS_W-1:0] dq);
        t_nsc = nsc; t_nrb = nrb; t_ss = ss; t_se = se;
        t_mask = mask; t_comb = comb; t_di = di; t_dq = dq;
        N_sc = ADDR_W'(nsc); N_rb = 7'(nrb); Sym_Start = 4'(ss); Sym_End = 4'(se);
        Dmrs_Mask = mask; Comb_Off = comb; Dmrs_I = di; Dmrs_Q = dq;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        // Junk on the config inputs: the latched copy must be used.
        N_sc = '1; N_rb = 7'd3; Sym_Start = 4'd9; Sym_End = 4'd1;
        Dmrs_Mask = ~mask; Comb_Off = ~comb;
        check("check_busy", 32'(Busy), 1);
        check("check_ready", {30'd0, Dmrs_Ready, FFT_Ready}, 0);
        tick();
        check("start_cfg_err", 32'(Cfg_Err), 0);
    endtask

    task automatic cfg_err_case(input string tag, input int nsc, input int nrb,
                                input int ss, input int se);
        N_sc = ADDR_W'(nsc); N_rb = 7'(nrb); Sym_Start = 4'(ss); Sym_End = 4'(se);
        Dmrs_Mask = '0; Comb_Off = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check({tag, "_busy"}, 32'(Busy), 1);
        tick();
        check({tag, "_pulse"}, 32'(Cfg_Err), 1);
        check({tag, "_idle"}, 32'(Busy), 0);
        check({tag, "_nowr"}, 32'(RE_Valid_OUT), 0);
        tick();
        check({tag, "_pulse_end"}, 32'(Cfg_Err), 0);
        check({tag, "_nowr2"}, 32'(RE_Valid_OUT), 0);
    endtask

    // vmode: 0 valids always high, 1 FFT_Valid 1-0-0-1 pattern, 2 random valids.
    // abort_sym/abort_k < 0 disables the abort.
    task automatic run_slot(input int vmode, input int abort_sym, input int abort_k);
        int ph, m_sym, m_k, nre, iter, n_wr, n_sd, n_dacc, ndm;
        logic adv, last, is_dm, on_comb, abrt, aborted;
        logic [DATA_W-1:0] e_re, e_im;
        nre = 12 * t_nrb;
        m_sym = t_ss; m_k = 0; ph = 0; iter = 0;
        n_wr = 0; n_sd = 0; n_dacc = 0; aborted = 1'b0;
        while (ph != 3 && iter < 5000) begin
            iter++;
            // Start while busy must be ignored.
            Start = (iter == 1);
            FFT_I = DATA_W'(iter * 37 + 5);
            FFT_Q = DATA_W'(-(iter * 11 + 2));
            if (vmode == 0) begin
                FFT_Valid = 1'b1; Dmrs_Valid = 1'b1;
            end else if (vmode == 1) begin
                FFT_Valid = (iter % 4 == 1) || (iter % 4 == 0); Dmrs_Valid = 1'b1;
            end else begin
                FFT_Valid = 1'($urandom_range(0, 1));
                Dmrs_Valid = 1'($urandom_range(0, 1));
            end
            if (ph == 0) begin
                is_dm = t_mask[m_sym];
                on_comb = is_dm && (m_k[0] == t_comb);
                abrt = (m_sym == abort_sym) && (m_k == abort_k);
                Abort = abrt;
                #1;
                check("dmrs_ready", 32'(Dmrs_Ready), 32'(on_comb && !abrt));
                check("fft_ready", 32'(FFT_Ready), 32'(!is_dm && !abrt));
                if (is_dm)
                    adv = !abrt && (on_comb ? Dmrs_Valid : 1'b1);
                else
                    adv = !abrt && FFT_Valid;
                if (!is_dm) begin
                    e_re = FFT_I; e_im = FFT_Q;
                end else if (on_comb) begin
                    e_re = {{(DATA_W-DMRS_W){t_di[DMRS_W-1]}}, t_di};
                    e_im = {{(DATA_W-DMRS_W){t_dq[DMRS_W-1]}}, t_dq};
                end else begin
                    e_re = '0; e_im = '0;
                end
                last = (m_k == nre - 1);
                tick();
                Start = 1'b0; Abort = 1'b0;
                if (abrt) begin
                    aborted = 1'b1;
                    check("abort_idle", 32'(Busy), 0);
                    check("abort_nowr", 32'(RE_Valid_OUT), 0);
                    check("abort_symdone", 32'(Sym_Done), 0);
                    for (int i = 0; i < 3; i++) begin
                        tick();
                        check("abort_quiet", {29'd0, RE_Valid_OUT, Sym_Done, RE_Done}, 0);
                        check("abort_busy", 32'(Busy), 0);
                    end
                    ph = 3;
                end else begin
                    check("wr_valid", 32'(RE_Valid_OUT), 32'(adv));
                    check("sym_done", 32'(Sym_Done), 32'(adv && last));
                    if (adv) begin
                        check("wr_addr", 32'(Wr_addr), 32'(t_nsc + m_k));
                        check("wr_sym", 32'(Wr_sym), 32'(m_sym));
                        check("re_real", $unsigned(RE_Real), 32'(e_re));
                        check("re_imj", $unsigned(RE_Imj), 32'(e_im));
                        n_wr++;
                        if (on_comb) n_dacc++;
                        if (last) begin
                            n_sd++;
                            ph = 1;
                        end
                        m_k++;
                    end
                end
            end else if (ph == 1) begin
                #1;
                check("nextsym_ready", {30'd0, Dmrs_Ready, FFT_Ready}, 0);
                tick();
                Start = 1'b0;
                check("nextsym_nowr", {30'd0, RE_Valid_OUT, Sym_Done}, 0);
                check("nextsym_busy", 32'(Busy), 1);
                if (m_sym == t_se) begin
                    ph = 2;
                end else begin
                    m_sym++; m_k = 0; ph = 0;
                end
            end else begin
                #1;
                check("done_ready", {30'd0, Dmrs_Ready, FFT_Ready}, 0);
                check("done_early", 32'(RE_Done), 0);
                tick();
                Start = 1'b0;
                check("re_done", 32'(RE_Done), 1);
                check("done_idle", 32'(Busy), 0);
                tick();
                check("re_done_end", 32'(RE_Done), 0);
                ph = 3;
            end
        end
        check("slot_finished", 32'(ph), 3);
        FFT_Valid = 1'b0; Dmrs_Valid = 1'b0;
        if (!aborted) begin
            ndm = 0;
            for (int s = t_ss; s <= t_se; s++) if (t_mask[s]) ndm++;
            check("n_writes", 32'(n_wr), 32'(nre * (t_se - t_ss + 1)));
            check("n_symdone", 32'(n_sd), 32'(t_se - t_ss + 1));
            check("n_dmrs_acc", 32'(n_dacc), 32'(6 * t_nrb * ndm));
        end
    endtask

    initial begin
        RST_RE = 1'b1; Start = 1'b0; Abort = 1'b0;
        N_sc = '0; N_rb = '0; Sym_Start = '0; Sym_End = '0; Dmrs_Mask = '0;
        Comb_Off = 1'b0; Dmrs_I = '0; Dmrs_Q = '0; Dmrs_Valid = 1'b0;
        FFT_I = '0; FFT_Q = '0; FFT_Valid = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        RST_RE = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // DMRS symbol, comb 0, addresses 0..11
        start_slot(0, 1, 2, 2, 14'h0004, 1'b0, 9'sd5, -9'sd7);
        run_slot(0, -1, -1);

        // Comb offset 1 with negative DMRS sample, addresses 100..123
        start_slot(100, 2, 4, 4, 14'h0010, 1'b1, -9'sd3, 9'sd4);
        run_slot(0, -1, -1);

        // Full slot, DMRS on symbols 2 and 11, random valids on both streams
        start_slot(0, 4, 0, 13, 14'h0804, 1'b0, -9'sd256, 9'sd255);
        run_slot(2, -1, -1);

        // FFT back-pressure, 1-0-0-1
        start_slot(10, 1, 3, 3, 14'h0000, 1'b0, 9'sd0, 9'sd0);
        run_slot(1, -1, -1);

        // Upper boundary: allocation ends exactly at the last subcarrier, last symbol
        start_slot(1188, 1, 13, 13, 14'h0000, 1'b0, 9'sd0, 9'sd0);
        run_slot(0, -1, -1);

        // Rejected configurations
        cfg_err_case("err_span", 1190, 1, 0, 0);
        cfg_err_case("err_symorder", 0, 1, 5, 3);
        cfg_err_case("err_nrb0", 0, 0, 0, 0);
        cfg_err_case("err_symend", 0, 1, 0, 14);

        // Abort at k=7 of symbol 1, then a clean slot
        start_slot(20, 1, 0, 2, 14'h0002, 1'b1, 9'sd1, 9'sd2);
        run_slot(0, 1, 7);
        start_slot(0, 1, 2, 2, 14'h0004, 1'b0, 9'sd5, -9'sd7);
        run_slot(0, -1, -1);

        // Reset while a write is on the port
        start_slot(0, 1, 0, 0, 14'h0000, 1'b0, 9'sd0, 9'sd0);
        FFT_I = 18'sd77; FFT_Q = 18'sd88; FFT_Valid = 1'b1;
        tick();
        tick();
        check("prereset_valid", 32'(RE_Valid_OUT), 1);
        check("prereset_addr", 32'(Wr_addr), 1);
        #2;
        RST_RE = 1'b1;
        #1;
        check_idle_outputs("midslot_reset");
        #1;
        RST_RE = 1'b0;
        tick();
        check("after_reset_idle", 32'(Busy), 0);
        check("after_reset_nowr", 32'(RE_Valid_OUT), 0);
        FFT_Valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/re_mapper_multi.md
Name: re_mapper_multi

Overview:
- Parametrised successor of the PUSCH resource-element mapper.
- Maps one slot's allocated REs into the grid buffer, symbol by symbol, from Sym_Start to Sym_End.
- DMRS can occupy any set of symbols (bitmask) and uses a selectable comb offset; all other allocated symbols carry FFT data.
- Sits between the DMRS generator / FFT output and the grid RAM. Input flow control is valid/ready; output is a registered write port.

Parameters:
- DATA_W, 18, FFT sample width and output RE width.
- DMRS_W, 9, DMRS sample width; must be <= DATA_W.
- NSC_TOTAL, 1200, grid subcarriers per symbol.
- ADDR_W, 11, subcarrier address width.
- NSYM, 14, symbols per slot.

Ports:
- CLK_RE in 1: clock.
- RST_RE in 1: asynchronous, active-high reset.
- Start in 1: one-cycle pulse; latches config and begins a slot.
- Abort in 1: synchronous return to IDLE.
- N_sc in ADDR_W: first allocated subcarrier.
- N_rb in 7: allocated RBs.
- Sym_Start in 4: first allocated symbol.
- Sym_End in 4: last allocated symbol.
- Dmrs_Mask in NSYM: bit s=1 means symbol s is DMRS.
- Comb_Off in 1: DMRS on REs where k[0]==Comb_Off.
- Dmrs_I, Dmrs_Q in DMRS_W signed: DMRS sample.
- Dmrs_Valid in 1: DMRS sample valid.
- Dmrs_Ready out 1: DMRS sample accepted.
- FFT_I, FFT_Q in DATA_W signed: FFT sample.
- FFT_Valid in 1: FFT sample valid.
- FFT_Ready out 1: FFT sample accepted.
- RE_Real, RE_Imj out DATA_W signed: RE value to write.
- RE_Valid_OUT out 1: write strobe.
- Wr_addr out ADDR_W: grid subcarrier address.
- Wr_sym out 4: grid symbol index.
- Sym_Done out 1: one-cycle pulse with the last write of each symbol.
- RE_Done out 1: one-cycle pulse when the slot is complete.
- Busy out 1: high in any state other than IDLE.
- Cfg_Err out 1: one-cycle pulse when Start is rejected.

Behaviour:
- Reset:
  - State=IDLE.
  - All outputs 0: RE_Real, RE_Imj, Wr_addr, Wr_sym, RE_Valid_OUT, Sym_Done, RE_Done, Busy, Cfg_Err, Dmrs_Ready, FFT_Ready.
  - Internal counters 0.
  - Reset mid-slot discards the slot; no further writes.
- States: IDLE, CHECK, MAP_DMRS, MAP_DATA, NEXT_SYM, DONE.
- IDLE:
  - On Start, latch N_sc, N_rb, Sym_Start, Sym_End, Dmrs_Mask, Comb_Off; go to CHECK.
  - Inputs are not sampled again until the next Start.
- CHECK (1 cycle):
  - Error if N_rb==0, or N_sc+12*N_rb > NSC_TOTAL (computed at ADDR_W+1 bits), or Sym_Start > Sym_End, or Sym_End > NSYM-1.
  - On error: Cfg_Err pulses for 1 cycle; go to IDLE.
  - Otherwise: sym=Sym_Start, k=0, Nre=12*N_rb; go to MAP_DMRS if Dmrs_Mask[sym] else MAP_DATA.
- MAP_DMRS:
  - If k[0]==Comb_Off: Dmrs_Ready=1. Advance only when Dmrs_Valid=1; value is sign-extended to DATA_W.
  - If k[0]!=Comb_Off: Dmrs_Ready=0; write 0+j0 and advance unconditionally.
- MAP_DATA:
  - FFT_Ready=1; advance only when FFT_Valid=1; value is FFT_I/FFT_Q.
  - FFT_Valid or Dmrs_Valid while not ready is ignored; no sample is consumed.
- Advance:
  - Next cycle: RE_Valid_OUT=1, Wr_addr=N_sc+k, Wr_sym=sym.
  - Then k <= k+1.
  - Latency is exactly 1 cycle from accept to write strobe.
  - With no advance, RE_Valid_OUT=0 and k holds (stall).
- End of symbol:
  - When k==Nre-1 advances, Sym_Done is asserted with that write.
  - FSM goes to NEXT_SYM (1 cycle; both readies 0).
  - If sym==Sym_End go to DONE; else sym+1, k=0, choose MAP_DMRS/MAP_DATA from the mask.
- DONE: RE_Done pulses for 1 cycle; go to IDLE.
- Start while Busy is ignored.
- Abort in any non-IDLE state:
  - Next state IDLE; readies 0 that cycle.
  - Any write registered in the same cycle still appears.
  - No Sym_Done or RE_Done.
  - Abort has priority over all transitions.
- Counts per DMRS symbol:
  - DMRS samples consumed = 6*N_rb.
  - Zero REs written = 6*N_rb.
- Every slot writes exactly Nre*(Sym_End-Sym_Start+1) REs, with addresses strictly ascending within each symbol.

Test Plan:
- DMRS symbol, comb 0: N_sc=0, N_rb=1, Sym 2..2, mask bit2, Comb_Off=0, Dmrs_Valid always high -> 12 writes, addr 0..11; even addr=DMRS, odd=0; 6 DMRS accepts; Sym_Done with addr 11; RE_Done 2 cycles later.
- Comb offset + sign extension: N_sc=100, N_rb=2, Comb_Off=1, Dmrs_I=-3 -> odd k carries -3 sign-extended to 18 bits, even k zero; addr 100..123.
- Multi-DMRS slot: Sym 0..13, mask 0x0804, N_rb=4, random valids -> DMRS only on symbols 2 and 11; 48 writes per symbol; 14 Sym_Done pulses; 1 RE_Done.
- Back-pressure: FFT_Valid toggling 1-0-0-1 -> RE_Valid_OUT follows one cycle later, no duplicated or skipped addresses, k holds during gaps.
- Config errors: N_sc=1190, N_rb=1 -> Cfg_Err pulse, no writes; Sym_Start=5, Sym_End=3 -> Cfg_Err pulse.
- Abort/reset mid-slot: Abort at k=7 of symbol 1 -> IDLE, no Sym_Done/RE_Done; a new Start then runs cleanly. Asserting RST_RE mid-write clears all outputs immediately.
